nor_tree_checker: RTL

Parametrised WIDTH-input NOR checker that computes each result two ways and compares them.
- Reference path: direct reduction NOR.
- Structural path: pipelined tree of 2-input NOR gates.
It flags and counts any disagreement, and serves as the self-checking successor for validating 2-input-NOR decompositions across widths. It sits as a streaming checker: one sample in per cycle, one verdict out per cycle after a fixed latency.

---
 rtl/nor_tree_checker.sv | 129 ++++++++++++
 1 files changed

// File: rtl/nor_tree_checker.sv
// Streaming checker: reduction NOR vs. a registered tree of 2-input NORs, with mismatch flag/counter.
// Optional NOR_TREE_CHECKER_CAPTURE_EN adds capture of the first failing sample.
module nor_tree_checker #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_inject,
   input  logic             clear,
   output logic             out_valid,
   output logic             out_ref,
   output logic             out_tree,
   output logic             out_match,
   output logic             mismatch_sticky,
   output logic [CNT_W-1:0] mismatch_cnt
`ifdef NOR_TREE_CHECKER_CAPTURE_EN
   ,
   output logic [WIDTH-1:0] first_fail_data,
   output logic             first_fail_valid
`endif
);
   localparam int LEVELS = $clog2(WIDTH);

   // Level k holds ceil(WIDTH/2^k) terms; level 0 is the raw input.
   for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
      localparam int N = (WIDTH + (1 << k) - 1) >> k;
      logic [N-1:0] q;
      if (k == 0) begin : g_in
         assign q = in_data;
      end else begin : g_st
         localparam int NP = (WIDTH + (1 << (k - 1)) - 1) >> (k - 1);
         wire [N-1:0] nxt;
         for (genvar i = 0; i < N; i++) begin : g_bit
            if (2 * i + 1 < NP) begin : g_pair
               wire n_ab;
               assign n_ab   = ~(g_lvl[k-1].q[2*i] | g_lvl[k-1].q[2*i+1]);
               assign nxt[i] = ~(n_ab | n_ab);
            end else begin : g_pass
               assign nxt[i] = g_lvl[k-1].q[2*i];
            end
         end
         always_ff @(posedge clk) begin
            if (rst) q <= '0;
            else     q <= nxt;
         end
      end
   end

   logic [LEVELS:1] vld_pipe;
   logic [LEVELS:1] ref_pipe;
   logic [LEVELS:1] inj_pipe;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         ref_pipe <= '0;
         inj_pipe <= '0;
      end else begin
         vld_pipe[1] <= in_valid;
         ref_pipe[1] <= ~|in_data;
         inj_pipe[1] <= in_inject;
         for (int i = 2; i <= LEVELS; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            ref_pipe[i] <= ref_pipe[i-1];
            inj_pipe[i] <= inj_pipe[i-1];
         end
      end
   end

   logic tree_nor;
   logic mism;
   assign tree_nor = ~g_lvl[LEVELS].q[0] ^ inj_pipe[LEVELS];
   assign mism     = out_valid & ~out_match;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_ref   <= 1'b0;
         out_tree  <= 1'b0;
         out_match <= 1'b0;
      end else begin
         out_valid <= vld_pipe[LEVELS];
         out_ref   <= ref_pipe[LEVELS];
         out_tree  <= tree_nor;
         out_match <= (ref_pipe[LEVELS] == tree_nor);
      end
   end

   // Clear outranks a mismatch arriving on the same edge.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         mismatch_sticky <= 1'b0;
         mismatch_cnt    <= '0;
      end else if (mism) begin
         mismatch_sticky <= 1'b1;
         if (mismatch_cnt != {CNT_W{1'b1}}) mismatch_cnt <= mismatch_cnt + 1'b1;
      end
   end

`ifdef NOR_TREE_CHECKER_CAPTURE_EN
   logic [LEVELS:1][WIDTH-1:0] dat_pipe;
   logic [WIDTH-1:0]           out_dat;

   always_ff @(posedge clk) begin
      if (rst) begin
         dat_pipe <= '0;
         out_dat  <= '0;
      end else begin
         dat_pipe[1] <= in_data;
         for (int i = 2; i <= LEVELS; i++) dat_pipe[i] <= dat_pipe[i-1];
         out_dat <= dat_pipe[LEVELS];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         first_fail_data  <= '0;
         first_fail_valid <= 1'b0;
      end else if (mism && !first_fail_valid) begin
         first_fail_data  <= out_dat;
         first_fail_valid <= 1'b1;
      end
   end
`endif

endmodule
